// File: rtl/regfile_loader_pkg.sv
// Shared constants and state encoding for the register-file loader.
// Geometry, terminator/pad bytes, and the ASCII '0' offset used by the HLSM.
package regfile_loader_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic [7:0] TERM_B = 8'h0D;
  localparam logic [7:0] PAD_B  = 8'h20;
  localparam logic [7:0] ZERO_B = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_SETTLE,
    S_GO,
    S_HOLD
  } ld_state_t;

endpackage

// File: rtl/regfile_loader.sv
// Fills a DEPTHxDATA_W register file from a valid/ready byte stream,
// pads after a terminator, pulses go to the HLSM and waits for hlsm_done.
// Ports: Clk, Rst (sync, active-high), start, in_valid/in_data/in_ready,
// registered write port W_Addr/W_en/W_Data, go, hlsm_done, busy, count.
module regfile_loader
  import regfile_loader_pkg::*;
#(
  parameter int                DEPTH_P  = DEPTH,
  parameter int                ADDR_W_P = ADDR_W,
  parameter int                DATA_W_P = DATA_W,
  parameter logic [DATA_W_P-1:0] TERM   = TERM_B,
  parameter logic [DATA_W_P-1:0] PAD    = PAD_B
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_W_P-1:0] in_data,
  output logic                in_ready,
  output logic [ADDR_W_P-1:0] W_Addr,
  output logic                W_en,
  output logic [DATA_W_P-1:0] W_Data,
  output logic                go,
  input  logic                hlsm_done,
  output logic                busy,
  output logic [ADDR_W_P:0]   count
);

  ld_state_t             state;
  ld_state_t             state_n;
  logic [ADDR_W_P-1:0]   addr;
  logic                  acc;
  logic                  is_term;
  logic                  last;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign acc      = in_valid && in_ready;
  assign is_term  = (in_data == TERM);
  assign last     = (addr == ADDR_W_P'(DEPTH_P - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (start) state_n = S_LOAD;
      S_LOAD: begin
        if (acc) begin
          if (is_term)   state_n = S_PAD;
          else if (last) state_n = S_SETTLE;
        end
      end
      S_PAD:    if (last) state_n = S_SETTLE;
      S_SETTLE: state_n = S_GO;
      S_GO:     state_n = S_HOLD;
      S_HOLD:   if (hlsm_done) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= S_IDLE;
      addr   <= '0;
      count  <= '0;
      W_en   <= 1'b0;
      W_Addr <= '0;
      W_Data <= '0;
      go     <= 1'b0;
    end else begin
      state <= state_n;
      W_en  <= 1'b0;
      // go is high exactly while the FSM sits in GO
      go    <= (state_n == S_GO);
      unique case (1'b1)
        (state == S_IDLE) && start: begin
          addr  <= '0;
          count <= '0;
        end
        (state == S_LOAD) && acc && !is_term: begin
          W_en   <= 1'b1;
          W_Addr <= addr;
          W_Data <= in_data;
          addr   <= addr + 1'b1;
          if (count < (ADDR_W_P+1)'(DEPTH_P))
            count <= count + 1'b1;
        end
        (state == S_PAD): begin
          W_en   <= 1'b1;
          W_Addr <= addr;
          W_Data <= PAD;
          addr   <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
